// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB-Lite SRAM slave with programmable wait states, lane writes and two-cycle ERROR
module ahb_sram_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   mem [DEPTH];
    logic          accept, bad;
    logic [3:0]    lanes;
    logic          unused;

    assign unused    = ^{hburst, hprot, hmastlock};
    assign hreadyout = state_q != S_WAIT && state_q != S_ERR1;
    assign hresp     = state_q == S_ERR1 || state_q == S_ERR2;
    assign hrdata    = (state_q == S_LAST && !write_q) ? mem[idx_q] : 32'd0;
    assign accept    = hsel && hready && htrans[1] && hreadyout;
    assign bad       = ({2'b00, haddr[31:2]} >= 32'(DEPTH)) || hsize > 3'd2
                     || (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
    assign lanes     = size_q == 2'd2 ? 4'b1111 : size_q == 2'd1 ? (off_q[1] ? 4'b1100 : 4'b0011)
                     : 4'b0001 << off_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        if (state_q == S_WAIT) begin
            state_d = cnt_q == 4'd0 ? S_LAST : S_WAIT;
            cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept && bad) begin
            state_d = S_ERR1;
        end else if (accept) begin
            state_d = WAIT_CYCLES > 0 ? S_WAIT : S_LAST;
            cnt_d   = 4'(WAIT_CYCLES - 1);
            idx_d   = haddr[AW+1:2];
            off_d   = haddr[1:0];
            size_d  = hsize[1:0];
            write_d = hwrite;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            size_q  <= size_d;
            write_q <= write_d;
        end
    end

    // Write commits at the edge ending LAST; a reset at that edge abandons it
    always_ff @(posedge hclk) begin
        if (hresetn && state_q == S_LAST && write_q)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
    end
endmodule

// File: doc/ahb_sram_responder.md
Name: ahb_sram_responder

Overview:
- AHB-Lite responder (slave) backed by an internal word-addressed SRAM; the completion side of the AHB master's transfers, muxed back through the existing decoder/multiplexor.
- Adds programmable wait states, byte/halfword/word write lanes, and a two-cycle ERROR response for out-of-range, unaligned or unsupported-size accesses.

Parameters:
- DEPTH, 256, number of 32-bit words; valid when haddr[31:2] < DEPTH
- WAIT_CYCLES, 1, wait states (hreadyout=0 cycles) inserted per OKAY data phase; 0..15

Ports:
- hclk  in  1  clock, all state changes on rising edge
- hresetn  in  1  reset, synchronous, active-low
- hsel  in  1  slave select from decoder
- haddr  in  32  byte address
- hwrite  in  1  1=write, 0=read
- hsize  in  3  0=byte, 1=halfword, 2=word; others illegal
- hburst  in  3  ignored (each beat handled independently)
- hprot  in  4  ignored
- htrans  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ
- hmastlock  in  1  ignored
- hready  in  1  bus ready (muxed hreadyout)
- hwdata  in  32  write data, valid in data phase
- hreadyout  out  1  data-phase completion
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  32  read data

Behaviour:
- Reset (hresetn=0 at edge): state=IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0, latched address/control cleared. SRAM contents not cleared. Reset mid-transfer abandons it; no SRAM write occurs at that edge.
- Address phase accepted at an edge when hsel=1, hready=1, htrans[1]=1. Latch haddr, hwrite, hsize. IDLE/BUSY, or hsel=0 -> no transfer; next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- Error check at acceptance: ERROR if haddr[31:2] >= DEPTH, or hsize > 2, or hsize=1 with haddr[0]=1, or hsize=2 with haddr[1:0]!=0.
- States (outputs are Moore):
  IDLE: hreadyout=1, hresp=0.
  WAIT: hreadyout=0, hresp=0; counter counts down from WAIT_CYCLES-1; at 0 -> LAST.
  LAST: hreadyout=1, hresp=0; data phase completes.
  ERR1: hreadyout=0, hresp=1; always -> ERR2.
  ERR2: hreadyout=1, hresp=1.
- From IDLE/LAST/ERR2 at an edge: accepted+error -> ERR1; accepted+ok -> WAIT (WAIT_CYCLES>0) or LAST (WAIT_CYCLES=0); otherwise -> IDLE. In WAIT/ERR1, new address phases cannot be accepted because hready=0.
- Write: SRAM updated at the edge ending LAST (hwrite latched=1). Lanes: byte -> lane haddr[1:0], halfword -> lanes {haddr[1],0}..+1, word -> all four; hwdata taken from the same lanes. Untouched lanes keep their old value. ERROR transfers never write.
- Read: in LAST with latched hwrite=0, hrdata = SRAM[latched word index], full 32-bit word. This is combinational from SRAM so a write completing at the previous edge is visible. hrdata=0 in every other state and cycle.
- Back-to-back: a new address phase is accepted in the same cycle as LAST/ERR2, giving pipelined transfers with no bubble. Write-then-read to the same word returns the new data.
- hresp=1 never coincides with a written SRAM word or non-zero hrdata.

Test Plan:
- Reset with hresetn=0 for 2 cycles, including one asserted mid-WAIT -> hreadyout=1, hresp=0, hrdata=0 on the cycle after; no SRAM write from the abandoned transfer.
- WAIT_CYCLES=1: word write 0xDEADBEEF to 0x10, then word read of 0x10 back-to-back -> each data phase has exactly 1 hreadyout=0 cycle; read returns 0xDEADBEEF with hresp=0.
- Byte write 0xAA to 0x11, halfword write 0x1234 to 0x12 over word 0x00000000 -> word read of 0x10 returns 0x1234AA00.
- Word read at haddr=0x400 (DEPTH=256) -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), hrdata=0; next transfer proceeds normally.
- Halfword write at 0x21 and hsize=3 read at 0x20 -> both give two-cycle ERROR; word 0x20 is unchanged on readback.
- WAIT_CYCLES=0 build: 4-beat INCR word writes to 0x00..0x0C, then 4 SEQ reads -> hreadyout stays 1 throughout; reads return the written values in order. htrans=BUSY and hsel=0 cycles give OKAY and change nothing.
